// File: rtl/nx1_mux_if.sv
// nx1_mux_if: bus bundle for the N-to-1 registered bit multiplexer.
//   in      N      data inputs, in[0] is index 0
//   sel     SEL_W  binary index of the bit to forward
//   mux_out 1      registered selected bit
// master drives in/sel and observes mux_out; slave is the mux itself.
interface nx1_mux_if #(
    parameter int N     = 16,
    parameter int SEL_W = $clog2(N)
);
    logic [N-1:0]     in;
    logic [SEL_W-1:0] sel;
    logic             mux_out;

    modport master (output in, output sel, input mux_out);
    modport slave  (input in, input sel, output mux_out);
endinterface

// File: rtl/nx1_mux.sv
// nx1_mux: picks bit in[sel] from an N-bit vector and registers it.
//   clk      clock, rising edge
//   rst_n    asynchronous active-low reset, clears mux_out
//   bus      nx1_mux_if.slave: in (N), sel (SEL_W), mux_out (1)
// One cycle of latency, captured every cycle; an index >= N yields 0.
module nx1_mux #(
    parameter int N     = 16,
    parameter int SEL_W = $clog2(N)
) (
    input  logic      clk,
    input  logic      rst_n,
    nx1_mux_if.slave  bus
);

    logic sel_bit;

    // Compare-and-pick loop rather than a dynamic index: an out-of-range
    // sel simply matches nothing and leaves the default 0, so no X can leak.
    always_comb begin
        sel_bit = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (bus.sel == SEL_W'(i)) sel_bit = bus.in[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.mux_out <= 1'b0;
        else        bus.mux_out <= sel_bit;
    end

endmodule

// File: tb/tb_nx1_mux.sv
// tb_nx1_mux: directed and random checks of nx1_mux at N=16 and N=10.
module tb_nx1_mux;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    nx1_mux_if #(.N(16), .SEL_W(4)) b16 ();
    nx1_mux_if #(.N(10), .SEL_W(4)) b10 ();

    nx1_mux #(.N(16), .SEL_W(4)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16));
    nx1_mux #(.N(10), .SEL_W(4)) u10 (.clk(clk), .rst_n(rst_n), .bus(b10));

    // Reference: the bit at position s of an n-bit word, 0 past the top.
    function automatic logic ref_bit(input logic [15:0] v, input int s, input int n);
        if (s >= n) return 1'b0;
        return v[s];
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step16(input logic [15:0] v, input logic [3:0] s, input logic exp, input string tag);
        b16.in  = v;
        b16.sel = s;
        @(posedge clk); #1;
        check(tag, b16.mux_out, exp);
    endtask

    task automatic step10(input logic [9:0] v, input logic [3:0] s, input logic exp, input string tag);
        b10.in  = v;
        b10.sel = s;
        @(posedge clk); #1;
        check(tag, b10.mux_out, exp);
    endtask

    initial begin
        logic [15:0] rv16;
        logic [9:0]  rv10;
        logic [3:0]  rs16, rs10;

        // Reset holds output low across edges even with all-ones input.
        rst_n   = 1'b0;
        b16.in  = 16'hFFFF;
        b16.sel = 4'hF;
        b10.in  = 10'h3FF;
        b10.sel = 4'h9;
        #1;
        check("reset_t0_16", b16.mux_out, 1'b0);
        check("reset_t0_10", b10.mux_out, 1'b0);
        @(posedge clk); #1;
        check("reset_edge1", b16.mux_out, 1'b0);
        @(posedge clk); #1;
        check("reset_edge2", b16.mux_out, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_release_16", b16.mux_out, 1'b1);
        check("reset_release_10", b10.mux_out, 1'b1);

        // Walking selects.
        step16(16'h0200, 4'd6,  1'b0, "walk_s6");
        step16(16'h01E0, 4'd7,  1'b1, "walk_s7");
        step16(16'h0080, 4'd8,  1'b0, "walk_s8");
        step16(16'h0040, 4'd9,  1'b0, "walk_s9");

        // Multi-bit inputs.
        step16(16'h0620, 4'd10, 1'b1, "multi_s10");
        step16(16'h0010, 4'd11, 1'b0, "multi_s11");
        step16(16'h0008, 4'd12, 1'b0, "multi_s12");

        // Boundaries.
        step16(16'h8001, 4'd15, 1'b1, "bound_hi_1");
        step16(16'h8001, 4'd0,  1'b1, "bound_lo_1");
        step16(16'h7FFE, 4'd15, 1'b0, "bound_hi_0");
        step16(16'h7FFE, 4'd0,  1'b0, "bound_lo_0");

        // Mid-cycle select changes: output holds until the edge, then
        // takes the value for the last select applied.
        step16(16'h00F0, 4'd5,  1'b1, "glitch_pre");
        #2 b16.sel = 4'd4;
        #1 check("glitch_hold1", b16.mux_out, 1'b1);
        #1 b16.sel = 4'd0;
        #1 check("glitch_hold2", b16.mux_out, 1'b1);
        @(posedge clk); #1;
        check("glitch_final", b16.mux_out, 1'b0);

        // Asynchronous reset in the middle of operation.
        step16(16'h0001, 4'd0, 1'b1, "midrst_pre");
        #2 rst_n = 1'b0;
        #1 check("midrst_async", b16.mux_out, 1'b0);
        @(posedge clk); #1;
        check("midrst_held", b16.mux_out, 1'b0);
        rst_n = 1'b1;
        step16(16'h0001, 4'd0, 1'b1, "midrst_resume");

        // Non-power-of-two width: out-of-range index gives 0.
        step10(10'h3FF, 4'd12, 1'b0, "n10_oor12");
        step10(10'h3FF, 4'd9,  1'b1, "n10_top");
        step10(10'h3FF, 4'd15, 1'b0, "n10_oor15");
        step10(10'h3FF, 4'd10, 1'b0, "n10_oor10");
        step10(10'h001, 4'd0,  1'b1, "n10_lsb");

        // Random in/sel on both instances against the reference.
        for (int k = 0; k < 300; k++) begin
            rv16 = 16'($urandom);
            rs16 = 4'($urandom);
            rv10 = 10'($urandom);
            rs10 = 4'($urandom);
            b16.in  = rv16;
            b16.sel = rs16;
            b10.in  = rv10;
            b10.sel = rs10;
            @(posedge clk); #1;
            check("rand16", b16.mux_out, ref_bit(rv16, int'(rs16), 16));
            check("rand10", b10.mux_out, ref_bit({6'd0, rv10}, int'(rs10), 10));
        end

        // Data independence: fixed select, other bits toggled at random.
        for (int k = 0; k < 40; k++) begin
            rv16 = 16'($urandom);
            rv16[3] = k[0];
            step16(rv16, 4'd3, k[0], "indep");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
